// File: rtl/vec_pkg.sv
// vec_pkg: shared byte type and the deserializer's word-phase encoding
package vec_pkg;
    localparam int BYTE_W = 8;
    typedef logic [BYTE_W-1:0] byte_t;
    typedef enum logic {COLLECT, LAST} phase_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    // count up on inc, hold once every bit is set
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/serial_byte_deserializer.sv
// serial_byte_deserializer: packs a bit-serial stream into WIDTH-bit words with valid/ready output
module serial_byte_deserializer
    import vec_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             align,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_count
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] TOP = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt, cnt_nxt, k, pos;
    logic [WIDTH-1:0] sr, sr_nxt, data_nxt;
    logic             accept, done, consume, valid_nxt;
    phase_t           phase;

    // phase, backpressure, bit placement and next word/output state
    always_comb begin
        phase     = (cnt == TOP) ? LAST : COLLECT;
        bit_ready = align || !(phase == LAST && out_valid && !out_ready);
        accept    = bit_valid && bit_ready;
        k         = align ? '0 : cnt;
        pos       = LSB_FIRST ? k : TOP - k;
        sr_nxt    = align ? '0 : sr;
        if (accept) sr_nxt[pos] = bit_in;
        done      = accept && !align && phase == LAST;
        cnt_nxt   = accept ? (done ? '0 : k + 1'b1) : k;
        consume   = out_valid && out_ready;
        valid_nxt = done || (out_valid && !out_ready);
        data_nxt  = done ? sr_nxt : out_data;
    end

    // state registers; reset drops any pending word immediately
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt       <= '0;
            sr        <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            sr        <= sr_nxt;
            out_data  <= data_nxt;
            out_valid <= valid_nxt;
        end

    sat_counter #(.CNT_W(CNT_W)) u_word_count (
        .clk   (clk),
        .reset (reset),
        .inc   (consume),
        .count (word_count)
    );
endmodule

// File: tb/tb_serial_byte_deserializer.sv
// tb_serial_byte_deserializer: directed stimulus with queued expectations checked by an output monitor
module tb_serial_byte_deserializer;
    import vec_pkg::*;

    logic clk = 0, reset = 1, bit_in = 0, bit_valid = 0, align = 0, out_ready = 1;
    logic br0, br1, br2, ov0, ov1, ov2;
    byte_t od0, od1, od2;
    logic [15:0] wc0, wc1;
    logic [1:0]  wc2;

    byte_t q0[$], q1[$], q2[$];
    int hs0 = 0, hs1 = 0, hs2 = 0;
    int n_tests = 0, n_fail = 0, stalls = 0;

    always #5 clk = ~clk;

    serial_byte_deserializer dut0 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br0),
        .align(align), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .word_count(wc0));
    serial_byte_deserializer #(.LSB_FIRST(1)) dut1 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br1),
        .align(align), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .word_count(wc1));
    serial_byte_deserializer #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(br2),
        .align(align), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .word_count(wc2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_word(input byte_t msb, input byte_t lsb);
        q0.push_back(msb);
        q1.push_back(lsb);
        q2.push_back(msb);
    endtask

    task automatic send_bit(input logic b);
        logic r = 0;
        bit_valid = 1;
        bit_in = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            r = br0;
            @(posedge clk);
            #1;
            if (r) break;
            stalls++;
        end
        if (!r) check("bit_accept_timeout", 0, 1);
        bit_valid = 0;
        bit_in = 1'bx;
    endtask

    task automatic send_word(input byte_t seq, input byte_t msb, input byte_t lsb);
        expect_word(msb, lsb);
        for (int i = 7; i >= 0; i--) send_bit(seq[i]);
    endtask

    // scoreboard monitor: pops one expectation per output handshake
    always @(negedge clk) begin
        if (reset) begin
            q0.delete(); q1.delete(); q2.delete();
            hs0 = 0; hs1 = 0; hs2 = 0;
        end else begin
            if (ov0 && out_ready) begin
                if (q0.size() == 0) check("dut0_unexpected_word", 1, 0);
                else check("dut0_data", od0, q0.pop_front());
                check("dut0_word_count", wc0, hs0);
                hs0++;
            end
            if (ov1 && out_ready) begin
                if (q1.size() == 0) check("dut1_unexpected_word", 1, 0);
                else check("dut1_data", od1, q1.pop_front());
                check("dut1_word_count", wc1, hs1);
                hs1++;
            end
            if (ov2 && out_ready) begin
                if (q2.size() == 0) check("dut2_unexpected_word", 1, 0);
                else check("dut2_data", od2, q2.pop_front());
                check("dut2_word_count_sat", wc2, (hs2 > 3) ? 3 : hs2);
                hs2++;
            end
        end
    end

    initial begin
        #2;
        check("rst_out_valid", ov0, 0);
        check("rst_out_data", od0, 0);
        check("rst_word_count", wc0, 0);
        @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_bit_ready", br0, 1);
        @(posedge clk);
        #1;

        // MSB-first 0xB2 / LSB-first 0x4D, single-cycle valid with out_ready high
        send_word(8'hB2, 8'hB2, 8'h4D);
        @(negedge clk);
        check("t1_valid_high", ov0, 1);
        check("t1_data", od0, 8'hB2);
        check("t2_lsb_data", od1, 8'h4D);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t1_valid_one_cycle", ov0, 0);
        check("t1_data_retained", od0, 8'hB2);
        @(posedge clk);
        #1;

        // backpressure: 0xB2 then 0xFF with out_ready low
        out_ready = 0;
        stalls = 0;
        expect_word(8'hB2, 8'h4D);
        expect_word(8'hFF, 8'hFF);
        for (int i = 7; i >= 0; i--) send_bit(i == 7 || i == 5 || i == 4 || i == 1);
        for (int i = 0; i < 7; i++) send_bit(1);
        check("t3_no_early_stall", stalls, 0);
        bit_valid = 1;
        bit_in = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t3_bit_ready_low", br0, 0);
            check("t3_data_stable", od0, 8'hB2);
            check("t3_valid_held", ov0, 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        @(negedge clk);
        check("t3_bit_ready_released", br0, 1);
        @(posedge clk);
        #1;
        bit_valid = 0;
        bit_in = 1'bx;
        out_ready = 0;
        @(negedge clk);
        check("t3_same_edge_valid", ov0, 1);
        check("t3_same_edge_data", od0, 8'hFF);
        @(posedge clk);
        #1 out_ready = 1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_consumed", ov0, 0);

        // re-alignment after three stale bits
        @(posedge clk);
        #1;
        expect_word(8'hB2, 8'h4D);
        for (int i = 0; i < 3; i++) send_bit(1);
        align = 1;
        send_bit(1);
        align = 0;
        for (int i = 6; i >= 0; i--) send_bit((i == 5) || (i == 4) || (i == 1));
        @(negedge clk);
        check("t4_align_valid", ov0, 1);
        check("t4_align_data", od0, 8'hB2);
        @(posedge clk);
        #1;

        // asynchronous reset with a pending word and cnt == 5
        out_ready = 0;
        send_word(8'h0F, 8'h0F, 8'hF0);
        for (int i = 0; i < 5; i++) send_bit(1);
        @(negedge clk);
        check("t5_pending_valid", ov0, 1);
        check("t5_cnt_before", dut0.cnt, 5);
        @(posedge clk);
        #3 reset = 1;
        #1;
        check("t5_async_valid", ov0, 0);
        check("t5_async_data", od0, 0);
        check("t5_async_word_count", wc0, 0);
        check("t5_async_cnt", dut0.cnt, 0);
        @(posedge clk);
        #1 reset = 0;
        out_ready = 1;
        @(negedge clk);
        check("t5_ready_after_release", br0, 1);
        @(posedge clk);
        #1;
        send_word(8'h55, 8'h55, 8'hAA);

        // four more words: saturation on the 2-bit counter
        for (int w = 0; w < 4; w++) send_word(8'hC5, 8'hC5, 8'hA3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("end_q0_empty", q0.size(), 0);
        check("end_q1_empty", q1.size(), 0);
        check("end_q2_empty", q2.size(), 0);
        check("end_word_count", wc0, 5);
        check("end_word_count_lsb", wc1, 5);
        check("end_word_count_sat", wc2, 3);
        check("end_last_data_lsb", od1, 8'hA3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
